// File: rtl/debug_jtag_pkg.sv
// debug_jtag_pkg: shared FSM states, command-count helper and default widths for the JTAG sysclk bridge
package debug_jtag_pkg;
  typedef enum logic [1:0] {IDLE, CAPT, DISP, WAIT} state_t;
  localparam int DEF_DR_WIDTH = 38;
  localparam int DEF_ACT_BIT = 35;
  function automatic int num_cmds(input int ir_width);
    return 1 << ir_width;
  endfunction
endpackage

// File: rtl/debug_sync_edge.sv
// debug_sync_edge: synchronises an async level and flags its rising edge, muted while the chain warms up
module debug_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);
  localparam int CW = $clog2(SYNC_STAGES + 2);
  logic [SYNC_STAGES-1:0] chain;
  logic prev;
  logic [CW-1:0] warm;
  // sync chain, previous-level flop and warm-up countdown so a level high at reset release is not an edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chain <= '0;
      prev <= 1'b0;
      warm <= CW'(SYNC_STAGES + 1);
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      prev <= chain[SYNC_STAGES-1];
      if (warm != '0) warm <= warm - CW'(1);
    end
  end
  assign rise = chain[SYNC_STAGES-1] & ~prev & (warm == '0);
endmodule

// File: rtl/debug_jtag_sysclk_bridge.sv
// debug_jtag_sysclk_bridge: captures TCK-domain IR/DR updates in clk and dispatches one-hot command pulses
module debug_jtag_sysclk_bridge import debug_jtag_pkg::*; #(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = DEF_DR_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT = DEF_ACT_BIT,
  parameter logic [num_cmds(IR_WIDTH)-1:0] BLOCKING_MASK = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic [IR_WIDTH-1:0]           ir_in,
  input  logic [DR_WIDTH-1:0]           sr,
  input  logic                          cmd_done,
  input  logic                          overrun_clr,
  output logic [DR_WIDTH-1:0]           jdo,
  output logic [IR_WIDTH-1:0]           ir_q,
  output logic [num_cmds(IR_WIDTH)-1:0] take_action,
  output logic [num_cmds(IR_WIDTH)-1:0] take_no_action,
  output logic                          busy,
  output logic                          overrun
);
  localparam int NUM_CMDS = num_cmds(IR_WIDTH);
  state_t state, state_nxt;
  logic udr_rise, uir_rise, act;
  logic [SYNC_STAGES-1:0][IR_WIDTH-1:0] ir_pipe;
  logic [IR_WIDTH-1:0] ir_sync, cmd_idx;
  logic [NUM_CMDS-1:0] cmd_oh;
  debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr (
    .clk(clk), .reset_n(reset_n), .d(vs_udr), .rise(udr_rise)
  );
  debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir (
    .clk(clk), .reset_n(reset_n), .d(vs_uir), .rise(uir_rise)
  );
  assign ir_sync = ir_pipe[SYNC_STAGES-1];
  assign cmd_oh = NUM_CMDS'(1) << cmd_idx;
  assign busy = state != IDLE;
  // IR is quasi-static, so a plain flop chain of the same depth as the strobe is enough
  always_ff @(posedge clk) begin
    if (!reset_n) ir_pipe <= '0;
    else ir_pipe <= {ir_pipe[SYNC_STAGES-2:0], ir_in};
  end
  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  end
  // next-state: capture, dispatch, optionally hold until the core reports completion
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = udr_rise ? CAPT : IDLE;
      CAPT: state_nxt = DISP;
      DISP: state_nxt = (act && BLOCKING_MASK[cmd_idx]) ? WAIT : IDLE;
      WAIT: state_nxt = cmd_done ? IDLE : WAIT;
      default: state_nxt = IDLE;
    endcase
  end
  // datapath: IR latch, DR capture, registered one-cycle pulses and sticky overrun
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_q <= '0;
      jdo <= '0;
      cmd_idx <= '0;
      act <= 1'b0;
      take_action <= '0;
      take_no_action <= '0;
      overrun <= 1'b0;
    end else begin
      if (uir_rise) ir_q <= ir_sync;
      if (state == CAPT) begin
        jdo <= sr;
        cmd_idx <= uir_rise ? ir_sync : ir_q;
        act <= sr[ACT_BIT];
      end
      take_action <= (state == DISP && act) ? cmd_oh : '0;
      take_no_action <= (state == DISP && !act) ? cmd_oh : '0;
      overrun <= (udr_rise && state != IDLE) || (overrun && !overrun_clr);
    end
  end
endmodule

// File: tb/tb_debug_jtag_sysclk_bridge.sv
// tb_debug_jtag_sysclk_bridge: random and directed DR/IR updates scored against a queue of expected pulses
module tb_debug_jtag_sysclk_bridge;
  localparam logic [3:0] BMASK = 4'b0001;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic vs_udr = 1'b0, vs_uir = 1'b0, cmd_done = 1'b0, overrun_clr = 1'b0;
  logic [1:0] ir_in = '0;
  logic [37:0] sr = '0;
  logic [37:0] jdo;
  logic [1:0] ir_q;
  logic [3:0] take_action, take_no_action;
  logic busy, overrun;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [1:0] cur_ir = '0;
  typedef struct {
    int cyc;
    logic [3:0] ta;
    logic [3:0] tna;
    logic [37:0] jdo;
  } pulse_t;
  pulse_t exp_q[$];

  debug_jtag_sysclk_bridge #(.BLOCKING_MASK(BMASK)) dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .cmd_done(cmd_done), .overrun_clr(overrun_clr), .jdo(jdo), .ir_q(ir_q),
    .take_action(take_action), .take_no_action(take_no_action), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // monitor: every pulse must match the oldest expectation, on the predicted cycle
  always @(negedge clk) begin
    pulse_t e;
    if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_pulse: no pulse observed, expected at cycle %0d (now %0d)", exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    if ((take_action | take_no_action) != 4'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: ta=%b tna=%b expected none (cycle %0d)", take_action, take_no_action, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", 64'(cyc), 64'(e.cyc));
        check("take_action", 64'(take_action), 64'(e.ta));
        check("take_no_action", 64'(take_no_action), 64'(e.tna));
        check("jdo_at_pulse", 64'(jdo), 64'(e.jdo));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic ir_update(input logic [1:0] ir);
    @(negedge clk);
    ir_in = ir;
    vs_uir = 1'b1;
    cur_ir = ir;
    repeat (3) @(negedge clk);
    vs_uir = 1'b0;
    check("ir_q_update", 64'(ir_q), 64'(ir));
    repeat (2) @(negedge clk);
  endtask

  // one DR update; the model's command is the latest IR and bit 35 picks action vs no-action
  task automatic xfer(input logic [37:0] v, input bit with_ir, input logic [1:0] ir, input bit hold);
    logic [3:0] oh;
    int k;
    @(negedge clk);
    if (with_ir) begin
      ir_in = ir;
      vs_uir = 1'b1;
      cur_ir = ir;
    end
    oh = 4'b0001 << cur_ir;
    sr = v;
    vs_udr = 1'b1;
    k = cyc + 1;
    exp_q.push_back('{k + 4, v[35] ? oh : 4'b0, v[35] ? 4'b0 : oh, v});
    repeat (3) @(negedge clk);
    vs_udr = 1'b0;
    vs_uir = 1'b0;
    repeat (3) @(negedge clk);
    check("jdo_hold", 64'(jdo), 64'(v));
    check("ir_q", 64'(ir_q), 64'(cur_ir));
    if (v[35] && BMASK[cur_ir]) begin
      check("busy_wait", 64'(busy), 64'd1);
      if (!hold) begin
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
        check("busy_done", 64'(busy), 64'd0);
      end
    end else check("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [37:0] v;
    int k;
    do_reset();
    check("rst_jdo", 64'(jdo), 64'd0);
    check("rst_ir_q", 64'(ir_q), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_take", 64'({take_action, take_no_action}), 64'd0);
    ir_update(2'b01);
    xfer(38'h0800000001, 1'b0, 2'b00, 1'b0);
    ir_update(2'b11);
    xfer(38'h0000000abc, 1'b0, 2'b00, 1'b0);
    ir_update(2'b00);
    xfer(38'h0812345678, 1'b0, 2'b00, 1'b1);
    @(negedge clk);
    sr = 38'h0fffffffff;
    vs_udr = 1'b1;
    repeat (3) @(negedge clk);
    vs_udr = 1'b0;
    check("overrun_set", 64'(overrun), 64'd1);
    check("overrun_jdo", 64'(jdo), 64'h0812345678);
    check("overrun_busy", 64'(busy), 64'd1);
    repeat (4) @(negedge clk);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    check("wait_release", 64'(busy), 64'd0);
    check("overrun_sticky", 64'(overrun), 64'd1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("overrun_clr", 64'(overrun), 64'd0);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    check("cmd_done_idle", 64'(busy), 64'd0);
    vs_udr = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check("warm_no_event", 64'(busy), 64'd0);
      @(negedge clk);
    end
    vs_udr = 1'b0;
    repeat (3) @(negedge clk);
    xfer(38'h0800000042, 1'b1, 2'b01, 1'b0);
    @(negedge clk);
    sr = 38'h0800000077;
    vs_udr = 1'b1;
    k = cyc + 1;
    while (cyc < k + 3) @(negedge clk);
    check("disp_busy", 64'(busy), 64'd1);
    check("disp_jdo", 64'(jdo), 64'h0800000077);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_disp_jdo", 64'(jdo), 64'd0);
    check("rst_disp_busy", 64'(busy), 64'd0);
    check("rst_disp_take", 64'({take_action, take_no_action}), 64'd0);
    reset_n = 1'b1;
    vs_udr = 1'b0;
    cur_ir = 2'b00;
    repeat (8) @(negedge clk);
    xfer(38'h0800000abc, 1'b1, 2'b10, 1'b0);
    for (int i = 0; i < 20; i++) begin
      v = {6'($urandom), 32'($urandom)};
      v[35] = 1'($urandom_range(0, 1));
      xfer(v, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected pulses never observed, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
